// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder_pkg
// Description : Shared definitions for the pipelined adder/subtractor:
//               operation encodings for the sub input, the configuration
//               check (WIDTH must split evenly into STAGES chunks) and the
//               per-stage chunk width computation.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_adder_pkg;

    // Encodings of the sub input
    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    // True when the WIDTH/STAGES pair describes a legal pipeline
    function automatic bit stages_divide_width(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Number of operand bits resolved by each stage
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage : pipe_adder_pkg
`default_nettype wire

// File: rtl/pipe_adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : adder_slice
// Description : One pipeline stage of pipe_adder. A CHUNK-bit ripple add
//               with carry-in, followed by the stage output register for
//               the sum bits and the carry-out. The register holds while
//               i_en is low and clears on the asynchronous reset.
// Ports       : clk, rst       - clock, async active-high reset
//               i_en           - register load enable (pipeline advance)
//               i_a, i_b       - operand chunks (b already conditioned)
//               i_cin          - carry into this chunk
//               o_sum, o_cout  - registered chunk sum and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] r_sum;
    logic             r_cout;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_sum  <= w_sum[CHUNK-1:0];
            r_cout <= w_sum[CHUNK];
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule : adder_slice
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder
// Description : Parametrised pipelined ripple-carry adder/subtractor.
//               The WIDTH-bit operation is split into STAGES chunks; stage k
//               resolves chunk k using the carry registered by stage k-1.
//               Upper operand chunks ride along in skew registers, finished
//               lower result chunks ride along in de-skew registers, so every
//               bit of a result appears at the output together, STAGES
//               cycles after it was accepted. Valid/ready on both sides with
//               a global stall (every register holds while the output is
//               back-pressured).
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_ready   - input handshake
//               a, b, sub           - operands, sub=1 selects a-b
//               out_valid/out_ready - output handshake
//               s                   - result, s[WIDTH] is the raw carry
//               ovf                 - signed overflow (PIPE_ADDER_OVF_EN only)
// Options     : define PIPE_ADDER_OVF_EN to add the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   s
);

    // An illegal WIDTH/STAGES pair collapses the chunk width to zero, which
    // breaks elaboration instead of silently building a wrong adder.
    localparam bit c_cfg_ok = stages_divide_width(WIDTH, STAGES);
    localparam int c_chunk  = c_cfg_ok ? chunk_width(WIDTH, STAGES) : 0;

    logic             w_stall;
    logic             w_en;
    logic             w_accept;
    logic             w_cin0;
    logic [WIDTH-1:0] w_b_eff;

    assign w_stall  = out_valid & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = ~rst & ~w_stall;
    assign w_accept = in_valid & in_ready;

    // Subtraction is a + ~b + 1: invert b and force the stage-0 carry-in.
    assign w_b_eff = (sub == ADD_OP) ? b : ~b;
    assign w_cin0  = (sub == SUB_OP);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand window seen by this stage: chunks k..STAGES-1, chunk k at bit 0
        localparam int c_win_w = WIDTH - k * c_chunk;

        logic [c_win_w-1:0]       w_a_win;
        logic [c_win_w-1:0]       w_b_win;
        logic                     w_cin;
        logic                     w_valid_in;
        logic                     r_valid;
        logic [c_chunk-1:0]       w_sum_q;
        logic                     w_cout_q;
        // Result chunks 0..k belonging to the op currently held in this stage
        logic [(k+1)*c_chunk-1:0] w_res;

        if (k == 0) begin : g_head
            assign w_a_win    = a;
            assign w_b_win    = w_b_eff;
            assign w_cin      = w_cin0;
            assign w_valid_in = w_accept;
            assign w_res      = w_sum_q;
        end else begin : g_body
            // De-skew: lower chunks already finished by earlier stages
            logic [k*c_chunk-1:0] r_lo;

            assign w_a_win    = g_stage[k-1].g_skew.r_a_skew;
            assign w_b_win    = g_stage[k-1].g_skew.r_b_skew;
            assign w_cin      = g_stage[k-1].w_cout_q;
            assign w_valid_in = g_stage[k-1].r_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lo <= '0;
                end else if (w_en) begin
                    r_lo <= g_stage[k-1].w_res;
                end
            end

            assign w_res = {w_sum_q, r_lo};
        end

        if (k < STAGES - 1) begin : g_skew
            // Skew: operand chunks not yet consumed, shifted down one chunk
            logic [c_win_w-c_chunk-1:0] r_a_skew;
            logic [c_win_w-c_chunk-1:0] r_b_skew;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_skew <= '0;
                    r_b_skew <= '0;
                end else if (w_en) begin
                    r_a_skew <= w_a_win[c_win_w-1:c_chunk];
                    r_b_skew <= w_b_win[c_win_w-1:c_chunk];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else if (w_en) begin
                r_valid <= w_valid_in;
            end
        end

        adder_slice #(
            .CHUNK (c_chunk)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_a    (w_a_win[c_chunk-1:0]),
            .i_b    (w_b_win[c_chunk-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_sum_q),
            .o_cout (w_cout_q)
        );
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign s         = {g_stage[STAGES-1].w_cout_q, g_stage[STAGES-1].w_res};

`ifdef PIPE_ADDER_OVF_EN
    // Carry-into-MSB XOR carry-out-of-MSB is equivalent to: both effective
    // operand MSBs agree and the result MSB differs from them. Registering
    // just the two operand MSBs of the last stage keeps ovf aligned with s.
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_en) begin
            r_a_msb <= g_stage[STAGES-1].w_a_win[c_chunk-1];
            r_b_msb <= g_stage[STAGES-1].w_b_win[c_chunk-1];
        end
    end

    assign ovf = (r_a_msb == r_b_msb) && (s[WIDTH-1] != r_a_msb);
`endif

endmodule : pipe_adder
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_adder
// Description : Self-checking bench for pipe_adder (WIDTH=16, STAGES=4).
//               Directed vectors with hand-computed results, a randomised
//               back-to-back run against a queue model, and reset while
//               operations are in flight. Covers ovf when PIPE_ADDER_OVF_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] s;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .s         (s)
    );

    // Reference result: carry bit is "no borrow" for subtraction
    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub);
        logic [15:0] diff;
        if (msub) begin
            diff = ma - mb;
            return {(ma >= mb), diff};
        end
        return {1'b0, ma} + {1'b0, mb};
    endfunction

    // Issue one op with out_ready high and wait for its result.
    // Entered and left 1 time unit after a rising edge. lat = -1 on timeout.
    task automatic send_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsub,
                           output logic [16:0] got, output int lat, output logic got_ovf);
        a = ta; b = tb_v; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        lat = 1; got = '0; got_ovf = 1'b0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
        end else begin
            got = s;
`ifdef PIPE_ADDER_OVF_EN
            got_ovf = ovf;
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (s !== 17'h0) begin errors++; $display("FAIL reset_s: got %h expected 00000", s); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_latency();
        logic [16:0] got; int lat; logic got_ovf;
        send_op(16'h1234, 16'h1111, 1'b0, got, lat, got_ovf);
        checks++; if (lat !== 4) begin errors++; $display("FAIL latency_cycles: got %0d expected 4", lat); end
        checks++; if (got !== 17'h02345) begin errors++; $display("FAIL latency_s: got %h expected 02345", got); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_no_dup: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_carry_ripple();
        logic [16:0] got; int lat; logic got_ovf;
        send_op(16'hFFFF, 16'h0001, 1'b0, got, lat, got_ovf);
        checks++; if (got !== 17'h10000) begin errors++; $display("FAIL ripple_s: got %h expected 10000", got); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency: got %0d expected 4", lat); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf: got %b expected 0", got_ovf); end
`endif
    endtask

    task automatic test_subtract();
        logic [16:0] got; int lat; logic got_ovf;
        send_op(16'h0005, 16'h0007, 1'b1, got, lat, got_ovf);
        checks++; if (got !== 17'h0FFFE) begin errors++; $display("FAIL sub_borrow_s: got %h expected 0fffe", got); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL sub_borrow_ovf: got %b expected 0", got_ovf); end
`endif
        send_op(16'h0007, 16'h0005, 1'b1, got, lat, got_ovf);
        checks++; if (got !== 17'h10002) begin errors++; $display("FAIL sub_noborrow_s: got %h expected 10002", got); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[$];
        logic [16:0] exp_s;
        logic        exp_ready;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while (recv < 20 && cyc < 600) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(0, 1));
            #1;
            exp_ready = !(out_valid && !out_ready);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL b2b_in_ready: cycle %0d got %b expected %b", cyc, in_ready, exp_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_result: got %h expected none", s);
                end else begin
                    exp_s = exp_q.pop_front();
                    if (s !== exp_s) begin
                        errors++; $display("FAIL b2b_s: result %0d got %h expected %h", recv, s, exp_s);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (recv !== 20) begin errors++; $display("FAIL b2b_received: got %0d expected 20", recv); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_lost: got %0d pending expected 0", exp_q.size()); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_in_flight();
        logic [16:0] got; int lat; logic got_ovf;
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'h1000 * 16'(i + 1); b = 16'h0101; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_head_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flight_stall_ready: got %b expected 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_reset_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flight_reset_ready: got %b expected 0", in_ready); end
        checks++; if (s !== 17'h0) begin errors++; $display("FAIL flight_reset_s: got %h expected 00000", s); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL flight_stale: got %0d valid cycles expected 0", stale); end
        send_op(16'h4321, 16'h0123, 1'b0, got, lat, got_ovf);
        checks++; if (got !== 17'h04444) begin errors++; $display("FAIL flight_new_s: got %h expected 04444", got); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL flight_new_latency: got %0d expected 4", lat); end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_overflow();
        logic [16:0] got; int lat; logic got_ovf;
        send_op(16'h7FFF, 16'h0001, 1'b0, got, lat, got_ovf);
        checks++; if (got !== 17'h08000) begin errors++; $display("FAIL ovf_pos_s: got %h expected 08000", got); end
        checks++; if (got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos: got %b expected 1", got_ovf); end
        send_op(16'h8000, 16'h0001, 1'b1, got, lat, got_ovf);
        checks++; if (got !== 17'h17FFF) begin errors++; $display("FAIL ovf_neg_s: got %h expected 17fff", got); end
        checks++; if (got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg: got %b expected 1", got_ovf); end
        send_op(16'h0001, 16'h0001, 1'b0, got, lat, got_ovf);
        checks++; if (got !== 17'h00002) begin errors++; $display("FAIL ovf_none_s: got %h expected 00002", got); end
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL ovf_none: got %b expected 0", got_ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_reset_in_flight();
`ifdef PIPE_ADDER_OVF_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_adder
`default_nettype wire
